// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage memory port between the core data path and a valid/ack data bus.
//
// Turns the MEM-stage access (address, store data, fun3 op, load/store) into a bus request
// with byte enables and lane-replicated store data, stalls the pipeline while the bus is busy,
// and registers the formatted (sign/zero-extended) load result for the WB stage. Misaligned,
// illegal-op, bus-error and timed-out accesses raise a one-cycle access_fault pulse.
//
// Ports
//   clk, reset_n     core clock, asynchronous active-low reset
//   mem_addr_mem     MEM-stage byte address
//   mem_wdata_mem    MEM-stage store data
//   mem_op_mem       fun3: 000 B, 001 H, 010 W, 100 BU, 101 HU (others illegal)
//   mem_write_mem    store in MEM
//   mem_to_reg_mem   load in MEM
//   mem_stage_en     MEM->WB register enable this cycle
//   mem_rdata_wb     formatted load data for WB
//   lsu_stall        hold pipeline registers and PC
//   access_fault     one-cycle pulse on a faulting access
//   bus_req/we/addr/be/wdata   bus request side
//   bus_ack/rdata/err          bus response side
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] mem_addr_mem,
  input  logic [31:0] mem_wdata_mem,
  input  logic [2:0]  mem_op_mem,
  input  logic        mem_write_mem,
  input  logic        mem_to_reg_mem,
  input  logic        mem_stage_en,
  output logic [31:0] mem_rdata_wb,
  output logic        lsu_stall,
  output logic        access_fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT_CYCLES);
  localparam bit TimeoutEn = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDone
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;

  logic        acc;
  logic        is_store;
  logic        is_load;
  logic        op_legal;
  logic        misaligned;
  logic        bad_acc;
  logic        good_acc;
  logic        in_flight;
  logic        timeout_hit;
  logic        timeout_fault;
  logic        bad_now;
  logic        ack_ok;
  logic        resolve;
  logic        load_zero;
  logic        load_done;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rdata_fmt;
  logic [3:0]  store_be;
  logic [31:0] store_wdata;

  // MEM inputs may still show an aborted access while reset is low; gating with reset_n keeps
  // every combinational output (bus_req in particular) quiet for the whole reset period.
  assign acc      = reset_n & (mem_write_mem | mem_to_reg_mem);
  assign is_store = mem_write_mem;
  assign is_load  = mem_to_reg_mem & ~mem_write_mem;

  // Op legality and natural alignment.
  always_comb begin
    op_legal   = 1'b0;
    misaligned = 1'b0;
    case (mem_op_mem)
      3'b000, 3'b100: op_legal = 1'b1;
      3'b001, 3'b101: begin
        op_legal   = 1'b1;
        misaligned = mem_addr_mem[0];
      end
      3'b010: begin
        op_legal   = 1'b1;
        misaligned = |mem_addr_mem[1:0];
      end
      default: ;
    endcase
  end

  assign bad_acc  = acc & (~op_legal | misaligned);
  assign good_acc = acc & ~bad_acc;

  // A good access not yet performed: DONE means the bus transfer already happened while
  // MEM was held by some other stall, so it must not be reissued.
  assign in_flight   = good_acc & (state_q != StDone);
  assign timeout_hit = TimeoutEn && (state_q == StWait) && (cnt_q == TimeoutVal);

  assign bus_req   = in_flight & ~timeout_hit;
  assign ack_ok    = bus_req & bus_ack;
  assign lsu_stall = in_flight & ~bus_ack & ~timeout_hit;

  // Bad accesses are only judged in IDLE; a held bad access in DONE must not pulse again.
  assign bad_now       = bad_acc & (state_q == StIdle);
  assign timeout_fault = timeout_hit & in_flight;
  assign access_fault  = bad_now | (ack_ok & bus_err) | timeout_fault;

  // The access ends this cycle, one way or another.
  assign resolve = bad_now | ack_ok | timeout_fault;

  assign load_zero = is_load & (bad_now | timeout_fault | (ack_ok & bus_err));
  assign load_done = is_load & ack_ok;

  // Store lane placement.
  always_comb begin
    store_be    = 4'b1111;
    store_wdata = mem_wdata_mem;
    case (mem_op_mem[1:0])
      2'b00: begin
        store_be    = 4'b0001 << mem_addr_mem[1:0];
        store_wdata = {4{mem_wdata_mem[7:0]}};
      end
      2'b01: begin
        store_be    = mem_addr_mem[1] ? 4'b1100 : 4'b0011;
        store_wdata = {2{mem_wdata_mem[15:0]}};
      end
      default: ;
    endcase
  end

  // Request fields are zero whenever no request is presented.
  assign bus_we    = bus_req & is_store;
  assign bus_addr  = bus_req ? {mem_addr_mem[31:2], 2'b00} : 32'h0;
  assign bus_be    = bus_req ? (is_store ? store_be : 4'b1111) : 4'b0000;
  assign bus_wdata = bus_we ? store_wdata : 32'h0;

  // Load lane selection and extension.
  always_comb begin
    unique case (mem_addr_mem[1:0])
      2'b00: rd_byte = bus_rdata[7:0];
      2'b01: rd_byte = bus_rdata[15:8];
      2'b10: rd_byte = bus_rdata[23:16];
      default: rd_byte = bus_rdata[31:24];
    endcase
    rd_half = mem_addr_mem[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (mem_op_mem)
      3'b000:  rdata_fmt = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  rdata_fmt = {24'h0, rd_byte};
      3'b001:  rdata_fmt = {{16{rd_half[15]}}, rd_half};
      3'b101:  rdata_fmt = {16'h0, rd_half};
      default: rdata_fmt = bus_rdata;
    endcase
  end

  // Access FSM, wait counter and WB load register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      mem_rdata_wb <= 32'h0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (resolve) begin
            state_q <= mem_stage_en ? StIdle : StDone;
          end else if (bus_req) begin
            state_q <= StWait;
            cnt_q   <= CntW'(1);
          end
        end
        StWait: begin
          if (resolve) begin
            state_q <= mem_stage_en ? StIdle : StDone;
            cnt_q   <= '0;
          end else if (!in_flight) begin
            // Access withdrawn under us (e.g. a flush): abandon it.
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (cnt_q != '1) begin
            // Saturate so a disabled timeout never wraps.
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDone: begin
          if (mem_stage_en) state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase

      if (load_zero) begin
        mem_rdata_wb <= 32'h0;
      end else if (load_done) begin
        mem_rdata_wb <= rdata_fmt;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] mem_addr_mem;
  logic [31:0] mem_wdata_mem;
  logic [2:0]  mem_op_mem;
  logic        mem_write_mem;
  logic        mem_to_reg_mem;
  logic        mem_stage_en;
  logic [31:0] mem_rdata_wb;
  logic        lsu_stall;
  logic        access_fault;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  load_store_unit #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .mem_addr_mem  (mem_addr_mem),
    .mem_wdata_mem (mem_wdata_mem),
    .mem_op_mem    (mem_op_mem),
    .mem_write_mem (mem_write_mem),
    .mem_to_reg_mem(mem_to_reg_mem),
    .mem_stage_en  (mem_stage_en),
    .mem_rdata_wb  (mem_rdata_wb),
    .lsu_stall     (lsu_stall),
    .access_fault  (access_fault),
    .bus_req       (bus_req),
    .bus_we        (bus_we),
    .bus_addr      (bus_addr),
    .bus_be        (bus_be),
    .bus_wdata     (bus_wdata),
    .bus_ack       (bus_ack),
    .bus_rdata     (bus_rdata),
    .bus_err       (bus_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wd;
    logic [2:0]  op;
    logic        wr;
    logic        ld;
    logic        ack;
    logic        err;
    logic [31:0] rdata;
    logic        e_req;
    logic        e_we;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_fault;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", nm, got, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_addr_mem   = 32'h0;
    mem_wdata_mem  = 32'h0;
    mem_op_mem     = 3'b000;
    mem_write_mem  = 1'b0;
    mem_to_reg_mem = 1'b0;
    mem_stage_en   = 1'b1;
    bus_ack        = 1'b0;
    bus_rdata      = 32'h0;
    bus_err        = 1'b0;
  endtask

  // Called at posedge+1 with the LSU idle; leaves inputs idle at posedge+1.
  task automatic zero_wait_load(input logic [31:0] a, input logic [31:0] rd, input string nm);
    mem_addr_mem   = a;
    mem_op_mem     = 3'b010;
    mem_to_reg_mem = 1'b1;
    mem_stage_en   = 1'b1;
    bus_ack        = 1'b1;
    bus_rdata      = rd;
    @(negedge clk);
    chk({nm, "_stall"}, 32'(lsu_stall), 32'h0);
    @(posedge clk); #1;
    chk({nm, "_rd"}, mem_rdata_wb, rd);
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int reqs;
    vec_t v;

    //        addr          wd            op      wr    ld    ack   err   rdata
    //        req   we    be       wdata         fault rd_wb
    vecs.push_back('{32'h100, 32'h0, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF,
                     1'b1, 1'b0, 4'hF, 32'h0, 1'b0, 32'hDEADBEEF});
    vecs.push_back('{32'h103, 32'h0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h80FF0000,
                     1'b1, 1'b0, 4'hF, 32'h0, 1'b0, 32'hFFFFFF80});
    vecs.push_back('{32'h103, 32'h0, 3'b100, 1'b0, 1'b1, 1'b1, 1'b0, 32'h80FF0000,
                     1'b1, 1'b0, 4'hF, 32'h0, 1'b0, 32'h00000080});
    vecs.push_back('{32'h102, 32'h0, 3'b001, 1'b0, 1'b1, 1'b1, 1'b0, 32'h80FF0000,
                     1'b1, 1'b0, 4'hF, 32'h0, 1'b0, 32'hFFFF80FF});
    vecs.push_back('{32'h100, 32'h0, 3'b101, 1'b0, 1'b1, 1'b1, 1'b0, 32'h12348001,
                     1'b1, 1'b0, 4'hF, 32'h0, 1'b0, 32'h00008001});
    vecs.push_back('{32'h101, 32'h0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00007F00,
                     1'b1, 1'b0, 4'hF, 32'h0, 1'b0, 32'h0000007F});
    vecs.push_back('{32'h201, 32'h12345678, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,
                     1'b1, 1'b1, 4'b0010, 32'h78787878, 1'b0, 32'h0000007F});
    vecs.push_back('{32'h202, 32'h1234ABCD, 3'b001, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,
                     1'b1, 1'b1, 4'b1100, 32'hABCDABCD, 1'b0, 32'h0000007F});
    vecs.push_back('{32'h204, 32'hCAFEF00D, 3'b010, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,
                     1'b1, 1'b1, 4'b1111, 32'hCAFEF00D, 1'b0, 32'h0000007F});
    vecs.push_back('{32'h101, 32'h0, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,
                     1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 32'h0});
    vecs.push_back('{32'h108, 32'h0, 3'b010, 1'b0, 1'b1, 1'b1, 1'b1, 32'h55555555,
                     1'b1, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0});
    vecs.push_back('{32'h10C, 32'h0, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0, 32'h11223344,
                     1'b1, 1'b0, 4'hF, 32'h0, 1'b0, 32'h11223344});
    vecs.push_back('{32'h203, 32'h1234ABCD, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,
                     1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 32'h11223344});
    vecs.push_back('{32'h110, 32'h0, 3'b011, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,
                     1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 32'h0});
    vecs.push_back('{32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,
                     1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0});
    vecs.push_back('{32'h303, 32'h000000A5, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,
                     1'b1, 1'b1, 4'b1000, 32'hA5A5A5A5, 1'b0, 32'h0});
    vecs.push_back('{32'h306, 32'h0, 3'b101, 1'b0, 1'b1, 1'b1, 1'b0, 32'hBEEF1234,
                     1'b1, 1'b0, 4'hF, 32'h0, 1'b0, 32'h0000BEEF});

    // Reset state.
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(bus_req), 32'h0);
    chk("rst_stall", 32'(lsu_stall), 32'h0);
    chk("rst_fault", 32'(access_fault), 32'h0);
    chk("rst_rd", mem_rdata_wb, 32'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Zero-wait accesses, back to back with no bubble.
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      mem_addr_mem   = v.addr;
      mem_wdata_mem  = v.wd;
      mem_op_mem     = v.op;
      mem_write_mem  = v.wr;
      mem_to_reg_mem = v.ld;
      mem_stage_en   = 1'b1;
      bus_ack        = v.ack;
      bus_err        = v.err;
      bus_rdata      = v.rdata;
      @(negedge clk);
      chk($sformatf("v%0d_req", i), 32'(bus_req), 32'(v.e_req));
      chk($sformatf("v%0d_we", i), 32'(bus_we), 32'(v.e_we));
      chk($sformatf("v%0d_be", i), 32'(bus_be), 32'(v.e_be));
      chk($sformatf("v%0d_addr", i), bus_addr, v.e_req ? (v.addr & 32'hFFFF_FFFC) : 32'h0);
      chk($sformatf("v%0d_wdata", i), bus_wdata, v.e_wdata);
      chk($sformatf("v%0d_stall", i), 32'(lsu_stall), 32'h0);
      chk($sformatf("v%0d_fault", i), 32'(access_fault), 32'(v.e_fault));
      @(posedge clk); #1;
      chk($sformatf("v%0d_rd", i), mem_rdata_wb, v.e_rd);
    end
    idle_inputs();
    @(posedge clk); #1;

    // SH with three wait cycles: stall exactly 3 cycles, request stable.
    mem_addr_mem  = 32'h202;
    mem_wdata_mem = 32'h1234ABCD;
    mem_op_mem    = 3'b001;
    mem_write_mem = 1'b1;
    mem_stage_en  = 1'b0;
    n = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (lsu_stall) n++;
      chk($sformatf("sh_wait%0d_req", c), 32'(bus_req), 32'h1);
      chk($sformatf("sh_wait%0d_addr", c), bus_addr, 32'h200);
      chk($sformatf("sh_wait%0d_be", c), 32'(bus_be), 32'hC);
      chk($sformatf("sh_wait%0d_wdata", c), bus_wdata, 32'hABCDABCD);
      @(posedge clk); #1;
    end
    bus_ack      = 1'b1;
    mem_stage_en = 1'b1;
    @(negedge clk);
    chk("sh_ack_stall", 32'(lsu_stall), 32'h0);
    chk("sh_ack_req", 32'(bus_req), 32'h1);
    @(posedge clk); #1;
    chk("sh_stall_cycles", 32'(n), 32'd3);
    idle_inputs();
    @(negedge clk);
    chk("sh_after_req", 32'(bus_req), 32'h0);
    @(posedge clk); #1;

    // Load acked while MEM held for two cycles: one request, data held.
    mem_addr_mem   = 32'h120;
    mem_op_mem     = 3'b010;
    mem_to_reg_mem = 1'b1;
    mem_stage_en   = 1'b0;
    bus_ack        = 1'b1;
    bus_rdata      = 32'hA5A5A5A5;
    reqs = 0;
    @(negedge clk);
    if (bus_req) reqs++;
    chk("hold_c0_stall", 32'(lsu_stall), 32'h0);
    @(posedge clk); #1;
    chk("hold_c0_rd", mem_rdata_wb, 32'hA5A5A5A5);
    bus_ack   = 1'b0;
    bus_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    if (bus_req) reqs++;
    chk("hold_c1_stall", 32'(lsu_stall), 32'h0);
    @(posedge clk); #1;
    mem_stage_en = 1'b1;
    @(negedge clk);
    if (bus_req) reqs++;
    @(posedge clk); #1;
    chk("hold_reqs", 32'(reqs), 32'd1);
    chk("hold_rd", mem_rdata_wb, 32'hA5A5A5A5);
    idle_inputs();

    // Misaligned load while MEM held: fault pulses once only, data zeroed.
    mem_addr_mem   = 32'h101;
    mem_op_mem     = 3'b010;
    mem_to_reg_mem = 1'b1;
    mem_stage_en   = 1'b0;
    @(negedge clk);
    chk("badhold_fault0", 32'(access_fault), 32'h1);
    chk("badhold_stall0", 32'(lsu_stall), 32'h0);
    @(posedge clk); #1;
    chk("badhold_rd", mem_rdata_wb, 32'h0);
    @(negedge clk);
    chk("badhold_fault1", 32'(access_fault), 32'h0);
    chk("badhold_req1", 32'(bus_req), 32'h0);
    @(posedge clk); #1;
    mem_stage_en = 1'b1;
    @(posedge clk); #1;
    idle_inputs();

    // Timeout: never-acked load stalls 4 cycles, then faults and drops the request.
    zero_wait_load(32'h140, 32'h0BADF00D, "pre_to");
    mem_addr_mem   = 32'h130;
    mem_op_mem     = 3'b010;
    mem_to_reg_mem = 1'b1;
    mem_stage_en   = 1'b0;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!lsu_stall) break;
      n++;
      @(posedge clk); #1;
    end
    chk("to_stall_cycles", 32'(n), 32'd4);
    chk("to_fault", 32'(access_fault), 32'h1);
    chk("to_req", 32'(bus_req), 32'h0);
    @(posedge clk); #1;
    chk("to_rd", mem_rdata_wb, 32'h0);
    chk("to_done_req", 32'(bus_req), 32'h0);
    mem_stage_en = 1'b1;
    @(posedge clk); #1;
    idle_inputs();

    // Reset asserted mid-WAIT drops the request at once.
    zero_wait_load(32'h144, 32'h7777AAAA, "pre_rst");
    mem_addr_mem   = 32'h150;
    mem_op_mem     = 3'b010;
    mem_to_reg_mem = 1'b1;
    mem_stage_en   = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrst_req_before", 32'(bus_req), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("midrst_req", 32'(bus_req), 32'h0);
    chk("midrst_stall", 32'(lsu_stall), 32'h0);
    chk("midrst_rd", mem_rdata_wb, 32'h0);
    idle_inputs();
    #2;
    reset_n = 1'b1;
    @(posedge clk); #1;
    zero_wait_load(32'h160, 32'h600DCAFE, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
